axis_rr_packet_arbiter: RTL

Four-input, single-clock AXI4-Stream packet arbiter that shares one downstream stream resource, typically the slave port of the asynchronous AXI-Stream FIFO, between up to four requesters in the crop-video pipeline. Grants are packet-granular: once a requester wins, it owns the output until its beat with `tlast` is accepted. Priority rotates round-robin. Output is registered, and per-port enables let software quiesce individual sources.

---
 rtl/axis_rr_packet_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Four-input AXI4-Stream packet arbiter with round-robin priority.
// A winner owns the registered output until its tlast beat is accepted.
module axis_rr_packet_arbiter #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_aresetn,
    input  logic [3:0]                        port_enable,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic                              s00_axis_tlast,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s01_axis_tstrb,
    input  logic                              s01_axis_tvalid,
    output logic                              s01_axis_tready,
    input  logic                              s01_axis_tlast,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s02_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s02_axis_tstrb,
    input  logic                              s02_axis_tvalid,
    output logic                              s02_axis_tready,
    input  logic                              s02_axis_tlast,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s03_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s03_axis_tstrb,
    input  logic                              s03_axis_tvalid,
    output logic                              s03_axis_tready,
    input  logic                              s03_axis_tlast,

    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic                              m00_axis_tlast,

    output logic [3:0]                        grant,
    output logic                              busy
);

    localparam int unsigned DATA_W    = C_AXIS_TDATA_WIDTH;
    localparam int unsigned STRB_W    = C_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned BEAT_W    = DATA_W + STRB_W + 1;
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned IDX_W     = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_d;
    logic                 busy_d;
    logic [IDX_W-1:0]     last_ptr_q, last_ptr_d;
    logic                 out_valid_d;
    logic [BEAT_W-1:0]    out_beat_d;

    logic [BEAT_W-1:0]    s_beat [NUM_PORTS];
    logic [NUM_PORTS-1:0] s_valid;
    logic [NUM_PORTS-1:0] s_ready;
    logic [NUM_PORTS-1:0] req_c;
    logic [IDX_W-1:0]     scan_idx_c;
    logic [IDX_W-1:0]     win_idx_c;
    logic                 win_found_c;
    logic [IDX_W-1:0]     own_idx_c;
    logic                 out_ready_c;
    logic                 accept_c;
    logic [BEAT_W-1:0]    sel_beat_c;
    logic                 sel_last_c;

    // Gather slave ports into indexable form; beat = {tlast, tstrb, tdata}
    assign s_beat[0] = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
    assign s_beat[1] = {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
    assign s_beat[2] = {s02_axis_tlast, s02_axis_tstrb, s02_axis_tdata};
    assign s_beat[3] = {s03_axis_tlast, s03_axis_tstrb, s03_axis_tdata};
    assign s_valid   = {s03_axis_tvalid, s02_axis_tvalid, s01_axis_tvalid, s00_axis_tvalid};
    assign req_c     = port_enable & s_valid;

    // Output register can take a beat when empty or draining this cycle
    assign out_ready_c = m00_axis_tready | ~m00_axis_tvalid;
    assign s_ready     = grant & {NUM_PORTS{out_ready_c}};
    assign accept_c    = |(s_valid & s_ready);

    assign s00_axis_tready = s_ready[0];
    assign s01_axis_tready = s_ready[1];
    assign s02_axis_tready = s_ready[2];
    assign s03_axis_tready = s_ready[3];

    // Round-robin pick: first request scanning upward from last_ptr+1
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        scan_idx_c  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_idx_c = last_ptr_q + IDX_W'(k);
            if (!win_found_c && req_c[scan_idx_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = scan_idx_c;
            end
        end
    end

    // Encode the one-hot grant into the owner's index
    always_comb begin
        own_idx_c = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                own_idx_c = IDX_W'(i);
            end
        end
    end

    assign sel_beat_c = s_beat[own_idx_c];
    assign sel_last_c = sel_beat_c[BEAT_W-1];

    // Next state, grant bookkeeping and output register load
    always_comb begin
        state_d     = state_q;
        grant_d     = grant;
        busy_d      = busy;
        last_ptr_d  = last_ptr_q;
        out_valid_d = m00_axis_tvalid;
        out_beat_d  = {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata};

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_beat_d  = sel_beat_c;
        end else if (m00_axis_tready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_found_c) begin
                    state_d = ST_XFER;
                    grant_d = NUM_PORTS'(1) << win_idx_c;
                    busy_d  = 1'b1;
                end
            end
            ST_XFER: begin
                if (accept_c && sel_last_c) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    last_ptr_d = own_idx_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state_q         <= ST_IDLE;
            grant           <= '0;
            busy            <= 1'b0;
            last_ptr_q      <= IDX_W'(3);
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            m00_axis_tlast  <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant           <= grant_d;
            busy            <= busy_d;
            last_ptr_q      <= last_ptr_d;
            m00_axis_tvalid <= out_valid_d;
            {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} <= out_beat_d;
        end
    end

endmodule
